// File: rtl/oc8051_comp_seq.sv
// Purpose : multi-cycle branch/compare condition evaluator (AZ, DES, CY, BIT, EQ, LT) on DW-bit operands, CW bits per cycle, MSB chunk first.
// Latency : RUN modes assert done in the cycle after edge N (N = DW/CW); CY/BIT/reserved modes assert done in the cycle after the accept edge.
// Backpres: start is accepted only in IDLE; a start during RUN or DONE is dropped (no queuing). The caller re-requests after done.
//
// Ports:
//   clk   - system clock, rising-edge
//   rst   - asynchronous, active-low reset
//   start - operation request, sampled in IDLE only
//   sel   - mode: 0 AZ, 1 DES, 2 CY, 3 BIT, 4 EQ, 5 LT, 6/7 reserved
//   b_in  - bit operand (BIT mode)
//   cy    - carry flag (CY mode)
//   acc   - accumulator operand
//   des   - ALU destination operand
//   src2  - second compare operand (EQ/LT)
//   busy  - high while an operation is in flight (state != IDLE)
//   done  - one-cycle completion pulse; eq/lt are valid from this cycle
//   eq    - condition result, held until the next completion
//   lt    - unsigned acc < src2 (EQ/LT modes only, 0 otherwise)
module oc8051_comp_seq #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    sel,
  input  logic          b_in,
  input  logic          cy,
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] des,
  input  logic [DW-1:0] src2,
  output logic          busy,
  output logic          done,
  output logic          eq,
  output logic          lt
);

  localparam int N    = DW / CW;
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] SEL_AZ  = 3'd0;
  localparam logic [2:0] SEL_DES = 3'd1;
  localparam logic [2:0] SEL_CY  = 3'd2;
  localparam logic [2:0] SEL_BIT = 3'd3;
  localparam logic [2:0] SEL_EQ  = 3'd4;
  localparam logic [2:0] SEL_LT  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // State and captured operation context
  state_t          state_q,   state_d;
  logic [2:0]      sel_q,     sel_d;
  logic [DW-1:0]   a_q,       a_d;
  logic [DW-1:0]   b_q,       b_d;
  logic [CNTW-1:0] cnt_q,     cnt_d;
  // Running comparison accumulators
  logic            eq_acc_q,  eq_acc_d;
  logic            lt_acc_q,  lt_acc_d;
  logic            decided_q, decided_d;
  // Registered results
  logic            eq_q,      eq_d;
  logic            lt_q,      lt_d;

  // Current chunk of each operand, selected by the chunk counter
  logic [CW-1:0]   a_ch;
  logic [CW-1:0]   b_ch;
  // Accumulator values including the chunk processed this cycle
  logic            eq_nxt;
  logic            lt_nxt;

  // Chunk mux: constant part-selects compared against the counter keep the
  // index expressions width-exact for any N.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CNTW'(i)) begin
        a_ch = a_q[i*CW +: CW];
        b_ch = b_q[i*CW +: CW];
      end
    end
  end

  // The first differing chunk (MSB first) fixes the unsigned ordering;
  // later chunks only feed the equality term.
  always_comb begin
    eq_nxt = eq_acc_q & (a_ch == b_ch);
    lt_nxt = lt_acc_q;
    if (!decided_q && (a_ch != b_ch)) begin
      lt_nxt = (a_ch < b_ch);
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    eq_acc_d  = eq_acc_q;
    lt_acc_d  = lt_acc_q;
    decided_d = decided_q;
    eq_d      = eq_q;
    lt_d      = lt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d     = sel;
          eq_acc_d  = 1'b1;
          lt_acc_d  = 1'b0;
          decided_d = 1'b0;
          cnt_d     = CNTW'(N - 1);
          case (sel)
            SEL_AZ: begin
              a_d     = acc;
              b_d     = '0;
              state_d = S_RUN;
            end
            SEL_DES: begin
              a_d     = des;
              b_d     = '0;
              state_d = S_RUN;
            end
            SEL_EQ, SEL_LT: begin
              a_d     = acc;
              b_d     = src2;
              state_d = S_RUN;
            end
            // Single-bit conditions resolve at the accept edge; eq is
            // registered directly so the flag inputs need no capture.
            SEL_CY: begin
              a_d     = '0;
              b_d     = '0;
              eq_d    = cy;
              lt_d    = 1'b0;
              state_d = S_DONE;
            end
            SEL_BIT: begin
              a_d     = '0;
              b_d     = '0;
              eq_d    = b_in;
              lt_d    = 1'b0;
              state_d = S_DONE;
            end
            default: begin
              a_d     = '0;
              b_d     = '0;
              eq_d    = 1'b0;
              lt_d    = 1'b0;
              state_d = S_DONE;
            end
          endcase
        end
      end

      S_RUN: begin
        eq_acc_d = eq_nxt;
        lt_acc_d = lt_nxt;
        if (!decided_q && (a_ch != b_ch)) begin
          decided_d = 1'b1;
        end
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == '0) begin
          // Last (least significant) chunk: publish the results.
          cnt_d   = '0;
          state_d = S_DONE;
          if (sel_q == SEL_LT) begin
            eq_d = lt_nxt;
          end else begin
            eq_d = eq_nxt;
          end
          if ((sel_q == SEL_EQ) || (sel_q == SEL_LT)) begin
            lt_d = lt_nxt;
          end else begin
            lt_d = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      eq_acc_q  <= 1'b0;
      lt_acc_q  <= 1'b0;
      decided_q <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      eq_acc_q  <= eq_acc_d;
      lt_acc_q  <= lt_acc_d;
      decided_q <= decided_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  // All outputs are decoded from flops only.
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_oc8051_comp_seq.sv
// Purpose : self-checking bench for oc8051_comp_seq at DW=16, CW=8 (N=2).
// Latency : expected done cycle is tracked per operation in the scoreboard.
// Backpres: start held high must be accepted only when the block is idle.
module tb_oc8051_comp_seq;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int N  = DW / CW;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    sel   = 3'd0;
  logic          b_in  = 1'b0;
  logic          cy    = 1'b0;
  logic [DW-1:0] acc   = '0;
  logic [DW-1:0] des   = '0;
  logic [DW-1:0] src2  = '0;
  logic          busy;
  logic          done;
  logic          eq;
  logic          lt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Last published results; eq/lt must hold these between done pulses.
  logic hold_eq = 1'b0;
  logic hold_lt = 1'b0;

  typedef struct {
    logic eq;
    logic lt;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  oc8051_comp_seq #(.DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sel   (sel),
    .b_in  (b_in),
    .cy    (cy),
    .acc   (acc),
    .des   (des),
    .src2  (src2),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .lt    (lt)
  );

  always #5 clk = ~clk;

  // cyc == k after rising edge k
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model on full-width operands.
  function automatic void model(input logic [2:0] s, input logic [DW-1:0] a, d, b2,
                                input logic c, bi,
                                output logic e, output logic l, output logic run);
    e = 1'b0; l = 1'b0; run = 1'b0;
    case (s)
      3'd0: begin e = (a == '0);  run = 1'b1; end
      3'd1: begin e = (d == '0);  run = 1'b1; end
      3'd2: begin e = c; end
      3'd3: begin e = bi; end
      3'd4: begin e = (a == b2); l = (a < b2); run = 1'b1; end
      3'd5: begin e = (a < b2);  l = (a < b2); run = 1'b1; end
      default: ;
    endcase
  endfunction

  // Output monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("eq",        32'(eq),   32'(mon_e.eq));
          chk("lt",        32'(lt),   32'(mon_e.lt));
          chk("done_cyc",  cyc,       mon_e.cyc);
          chk("busy_done", 32'(busy), 32'd1);
          hold_eq = mon_e.eq;
          hold_lt = mon_e.lt;
        end
      end else begin
        chk("hold_eq", 32'(eq), 32'(hold_eq));
        chk("hold_lt", 32'(lt), 32'(hold_lt));
      end
    end
  end

  task automatic scramble();
    sel  = 3'($urandom);
    acc  = DW'($urandom);
    des  = DW'($urandom);
    src2 = DW'($urandom);
    cy   = 1'($urandom);
    b_in = 1'($urandom);
  endtask

  // Wait (bounded) for all expected results, then require an idle cycle.
  task automatic wait_drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  // One operation; called while the DUT is idle, away from the rising edge.
  task automatic run_op(input logic [2:0] s, input logic [DW-1:0] a, d, b2,
                        input logic c, bi);
    logic e, l, r;
    exp_t x;
    int   e0;
    model(s, a, d, b2, c, bi, e, l, r);
    sel = s; acc = a; des = d; src2 = b2; cy = c; b_in = bi;
    start = 1'b1;
    @(posedge clk); #1;
    e0    = cyc;
    start = 1'b0;
    // Inputs change after the accept edge must not disturb the operation.
    scramble();
    x.eq  = e;
    x.lt  = l;
    x.cyc = r ? e0 + N : e0;
    sb.push_back(x);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] ra, rb, rd;
    exp_t x;
    int   next_ok;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_eq",   32'(eq),   32'd0);
    chk("rst_lt",   32'(lt),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // EQ mode
    run_op(3'd4, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0);
    run_op(3'd4, 16'h1234, 16'h0000, 16'h1235, 1'b0, 1'b0);
    // LT mode, MSB chunk decides (leaves eq=1, lt=1 for the reset test)
    run_op(3'd5, 16'h12FF, 16'h0000, 16'h1300, 1'b0, 1'b0);

    // Reset mid-operation
    sel = 3'd4; acc = 16'h0055; src2 = 16'h0055; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    hold_eq = 1'b0;
    hold_lt = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_eq",   32'(eq),   32'd0);
    chk("abort_lt",   32'(lt),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(3'd4, 16'h00AA, 16'h0000, 16'h00AA, 1'b0, 1'b0);

    // LT: swapped operands, and equality
    run_op(3'd5, 16'h1300, 16'h0000, 16'h12FF, 1'b0, 1'b0);
    run_op(3'd5, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0);
    // LT decided only in the low chunk
    run_op(3'd5, 16'h1310, 16'h0000, 16'h1320, 1'b0, 1'b0);

    // Zero modes
    run_op(3'd0, 16'h0000, 16'hFFFF, 16'h5555, 1'b0, 1'b0);
    run_op(3'd0, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0);
    run_op(3'd1, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0);
    run_op(3'd1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Direct modes
    run_op(3'd2, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(3'd2, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    run_op(3'd3, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(3'd3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    run_op(3'd7, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
    run_op(3'd6, 16'h0001, 16'h0000, 16'h0002, 1'b1, 1'b1);

    // Random mix across all modes
    for (int i = 0; i < 16; i++) begin
      ra = DW'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : DW'($urandom);
      if ($urandom_range(0, 3) == 0) rb[DW-1:CW] = ra[DW-1:CW];
      rd = ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom);
      run_op(3'($urandom_range(0, 7)), ra, rd, rb, 1'($urandom), 1'($urandom));
    end

    // Handshake: start held high; accepted only every N+2 cycles.
    sel = 3'd4; acc = 16'h00FF; src2 = 16'h0100; start = 1'b1;
    next_ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cyc >= next_ok) begin
        x.eq  = 1'b0;
        x.lt  = 1'b1;
        x.cyc = cyc + N;
        sb.push_back(x);
        next_ok = cyc + N + 2;
      end
    end
    start = 1'b0;
    scramble();
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
